// File: rtl/a23_gc_unloader.sv
// Run controller for a23_gc_main: releases the core on start, counts cycles to
// terminate, then streams a snapshot of the output memory over valid/ready.
module a23_gc_unloader #(
  parameter int OUT_MEM_SIZE = 64,
  parameter int CC_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       core_rst,
  input  logic                       terminate,
  input  logic [OUT_MEM_SIZE*32-1:0] o,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [CC_WIDTH-1:0]        cc,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CC_WIDTH-1:0]             cc_q, cc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [OUT_MEM_SIZE-1:0][31:0]   snap_q, snap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cc_q    <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cc_d    = '0;
        end
      end
      RUN: begin
        // The terminating edge itself is not counted.
        if (terminate) begin
          snap_d  = o;
          idx_d   = '0;
          state_d = DRAIN;
        end else if (cc_q != '1) begin
          cc_d = cc_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_rst  = (state_q != RUN);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = out_valid ? snap_q[idx_q] : 32'h0;
  assign cc        = cc_q;

endmodule

// File: tb/tb_a23_gc_unloader.sv
// Directed bench for a23_gc_unloader: run/drain, backpressure, restart,
// async reset mid-drain, and counter saturation on a narrow instance.
module tb_a23_gc_unloader;
  localparam int N = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0, terminate = 1'b0, out_ready = 1'b0;
  logic [N*32-1:0] o = '0;
  logic            core_rst, out_valid, out_last, busy, done;
  logic [31:0]     out_data;
  logic [31:0]     cc;

  logic            s_start = 1'b0, s_term = 1'b0, s_ready = 1'b1;
  logic [63:0]     s_o = '0;
  logic            s_core_rst, s_valid, s_last, s_busy, s_done;
  logic [31:0]     s_data;
  logic [3:0]      s_cc;

  int tests = 0, fails = 0;

  a23_gc_unloader #(.OUT_MEM_SIZE(N), .CC_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .core_rst(core_rst),
    .terminate(terminate), .o(o), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .cc(cc), .busy(busy), .done(done)
  );

  a23_gc_unloader #(.OUT_MEM_SIZE(2), .CC_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .core_rst(s_core_rst),
    .terminate(s_term), .o(s_o), .out_valid(s_valid), .out_ready(s_ready),
    .out_data(s_data), .out_last(s_last), .cc(s_cc), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_o(input logic [31:0] base);
    for (int j = 0; j < N; j++) o[32*j +: 32] = base + 32'(j);
  endtask

  // Start a run, hold terminate low for n_low RUN edges, then terminate.
  task automatic run(input int n_low, input logic [31:0] base);
    set_o(base);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_core_rst", core_rst, 0);
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    for (int i = 0; i < n_low; i++) begin
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    terminate = 1'b1;
    tick();
    terminate = 1'b0;
    chk("term_cc", cc, 64'(n_low));
    chk("term_core_rst", core_rst, 1);
    chk("term_valid", out_valid, 1);
  endtask

  // Drain all words; bp selects ready pattern 1,0,0,1; scr scrambles live o.
  task automatic drain(input logic [31:0] base, input bit bp, input bit scr);
    int k = 0;
    int cyc = 0;
    while (k < N && cyc < 1000) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      start = (cyc == 3);
      if (scr) for (int j = 0; j < N; j++) o[32*j +: 32] = $urandom;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 64'(base + 32'(k)));
      chk("drain_last", out_last, 64'(k == N - 1));
      if (out_ready) k++;
      cyc++;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("drain_count", 64'(k), 64'(N));
    chk("drain_done", done, 1);
    chk("drain_valid_off", out_valid, 0);
    chk("drain_busy_off", busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_cc", cc, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_core_rst", core_rst, 1);

    // Saturation on the 4-bit counter instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_cc15", s_cc, 15);
    end
    chk("sat_cc20", s_cc, 15);
    s_term = 1'b1;
    tick();
    s_term = 1'b0;
    chk("sat_cc_final", s_cc, 15);
    tick();
    tick();
    chk("sat_done", s_done, 1);

    // Basic run
    run(37, 32'hA500_0000);
    drain(32'hA500_0000, 1'b0, 1'b0);
    tick();
    chk("basic_cc_hold", cc, 37);

    // Restart from DONE with immediate terminate
    run(0, 32'hB000_0100);
    drain(32'hB000_0100, 1'b0, 1'b0);

    // Backpressure with live o scrambled after capture
    run(12, 32'hC000_0000);
    drain(32'hC000_0000, 1'b1, 1'b1);
    chk("bp_cc", cc, 12);

    // Async reset mid-drain at word 10
    run(5, 32'hD000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    out_ready = 1'b0;
    chk("pre_rst_data", out_data, 32'hD000_000A);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_core_rst", core_rst, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cc", cc, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_core_rst", core_rst, 1);
    chk("post_rst_idle_done", done, 0);
    run(2, 32'hE000_0000);
    drain(32'hE000_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/a23_gc_unloader.md
# a23_gc_unloader

Run controller and result unloader for `a23_gc_main`.
- Holds the core in reset until a run is requested, then releases it.
- Counts clock cycles until the core raises `terminate`.
- Snapshots the flat output-memory bus `o` and streams it out one 32-bit word at a time over a valid/ready handshake.
- Sits between `a23_gc_main` and the host/readout logic. It is the consumer end of the core's `o`/`terminate` result interface.

## Interface
- `OUT_MEM_SIZE`, 64, number of 32-bit output words on `o`.
- `CC_WIDTH`, 32, width of the cycle counter.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `core_rst`  out  1  reset to `a23_gc_main`; low only in RUN.
- `terminate`  in  1  core termination flag.
- `o`  in  OUT_MEM_SIZE*32  core output memory; word i = `o[32*i+31:32*i]`.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  32  streamed output word.
- `out_last`  out  1  current word is index OUT_MEM_SIZE-1.
- `cc`  out  CC_WIDTH  run cycle count.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE. The state is registered; every output is a registered signal or a decode of registered state.
- Reset (async, any state, mid-run or mid-drain included):
  - state = IDLE, `core_rst` = 1, `cc` = 0, word index = 0, snapshot = 0.
  - `out_valid`, `out_last`, `out_data`, `busy`, `done` all = 0.
- IDLE:
  - `core_rst` = 1.
  - `start` = 1 moves to RUN and clears `cc` to 0.
- RUN:
  - `core_rst` = 0 and `busy` = 1.
  - Each edge with `terminate` = 0 increments `cc`. At all-ones, `cc` saturates and does not wrap.
  - An edge with `terminate` = 1 does the following:
    - does not increment `cc`;
    - copies all of `o` into the snapshot register;
    - clears the word index to 0;
    - moves to DRAIN.
  - Result: `cc` equals the number of RUN edges on which `terminate` was low. `terminate` already high on the first RUN edge gives `cc` = 0.
  - `start` is ignored.
- DRAIN:
  - `core_rst` = 1 (core frozen). `busy` = 1 and `out_valid` = 1.
  - `out_data` = snapshot word[index]. `out_last` = (index == OUT_MEM_SIZE-1).
  - Changes on `o` after capture have no effect.
  - A handshake (`out_valid` & `out_ready` on an edge) increments the index.
  - A handshake while `out_last` = 1 moves to DONE instead.
  - With `out_ready` = 0, `out_data` and `out_last` hold stable.
  - `start` is ignored.
- DONE:
  - `done` = 1, `core_rst` = 1, `out_valid` = 0.
  - `cc` holds the final count.
  - `start` = 1 moves to RUN, clears `cc`, and drops `done` the next cycle.
- Word order: index 0 first, ascending to OUT_MEM_SIZE-1.
- Each word is emitted exactly once.

## Timing
- `start` sampled at edge N: `core_rst` low and `busy` high from edge N.
- `terminate` sampled high at edge T:
  - `out_valid` = 1 and `out_data` = word 0 from edge T.
  - `core_rst` rises at edge T.
- With `out_ready` held high, each word is on the bus for exactly one cycle:
  - word k is presented from edge T+k;
  - the last handshake occurs at edge T+OUT_MEM_SIZE-1;
  - `done` = 1 from edge T+OUT_MEM_SIZE.
- There are no bubbles between words while `out_ready` = 1.
- `terminate` and `start` are synchronous to `clk`; no synchronizers.

## Test plan
- Reset values: assert `rst` mid-DRAIN at word 10 -> immediately `core_rst`=1, `out_valid`=0, `cc`=0, `done`=0; after release the block sits in IDLE until `start`.
- Basic run:
  - Stimulus: `start` pulse; `terminate` rises after 37 RUN edges low; `o` word i = 0xA5000000+i; `out_ready`=1.
  - Required: `cc`=37; 64 consecutive words 0xA5000000..0xA500003F; `out_last` only on 0xA500003F; `done` the next cycle.
- Immediate terminate: `terminate`=1 already at the first RUN edge -> `cc`=0 and the drain is still a full 64 words.
- Backpressure:
  - Stimulus: toggle `out_ready` 1,0,0,1 repeating; change `o` randomly during DRAIN.
  - Required: words stay stable while stalled, arrive in order, no loss or duplicate, and carry the snapshot values, not the live `o`.
- Ignored start and restart: `start` pulsed during RUN and DRAIN has no effect. `start` in DONE -> `done`=0, `cc` restarts from 0, and a second drain completes.
- Saturation: CC_WIDTH=4 with `terminate` held low for 20 edges -> `cc`=15, with no wrap.
